// File: rtl/disp_scan_mux.sv
// Time-multiplexed BCD digit scanner for a common-cathode 7-segment display:
// double-buffered value, per-slot dead time, leading-zero and invalid-code blanking.
module disp_scan_mux #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*NDIG-1:0]   bcd_in,
    input  logic                lzb_en,
    input  logic                enable,
    output logic [3:0]          digit_bcd,
    output logic                digit_bl,
    output logic [NDIG-1:0]     digit_sel,
    output logic                frame_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] shadow;
    logic [4*NDIG-1:0] active;

    logic            slot_end;
    logic            frame_end;
    logic            show;
    logic [NDIG-1:0] lz_mask;
    logic            upper_zero;
    logic [3:0]      code;
    logic            lz_hit;
    logic            blank;

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == IDX_MAX);
    assign show      = (int'(cnt) >= DEAD);

    // lz_mask[i] is set when active digits i..NDIG-1 are all zero.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            upper_zero = upper_zero && (active[4*(NDIG-1-i) +: 4] == 4'd0);
            lz_mask[NDIG-1-i] = upper_zero;
        end
    end

    always_comb begin
        code   = 4'd0;
        lz_hit = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                code   = active[4*i +: 4];
                lz_hit = lz_mask[i] && (i != 0);
            end
        end
        blank = (code > 4'd9) || (lzb_en && lz_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            active <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end) begin
                idx <= frame_end ? '0 : idx + IW'(1);
            end
            if (load) begin
                shadow <= bcd_in;
            end
            if (frame_end) begin
                active <= shadow;
            end
        end
    end

    // Outputs describe the slot position held in cnt/idx before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_sel  <= '0;
            digit_bl   <= 1'b0;
            digit_bcd  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (show) begin
                digit_sel <= enable ? (NDIG'(1) << idx) : '0;
                digit_bl  <= !blank;
                digit_bcd <= blank ? 4'd0 : code;
            end else begin
                digit_sel <= '0;
                digit_bl  <= 1'b0;
                digit_bcd <= '0;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux with NDIG=4, PRESCALE=8, DEAD=2.
module tb_disp_scan_mux;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic        lzb_en;
    logic        enable;
    logic [3:0]  digit_bcd;
    logic        digit_bl;
    logic [3:0]  digit_sel;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    // Load schedule: two (edge, value) slots relative to reset release
    int          e1 = 0;
    int          e2 = 0;
    logic [15:0] v1 = '0;
    logic [15:0] v2 = '0;

    // Hand-computed expected display for the current frame
    logic [15:0] exp_val = '0;
    logic [3:0]  exp_bl  = '0;
    logic        exp_en  = 1'b1;

    disp_scan_mux #(
        .NDIG(4),
        .PRESCALE(8),
        .DEAD(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .bcd_in(bcd_in),
        .lzb_en(lzb_en),
        .enable(enable),
        .digit_bcd(digit_bcd),
        .digit_bl(digit_bl),
        .digit_sel(digit_sel),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d observed=timeout expected=finish", k);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        if (k + 1 == e1) begin
            load   = 1'b1;
            bcd_in = v1;
        end else if (k + 1 == e2) begin
            load   = 1'b1;
            bcd_in = v2;
        end else begin
            load = 1'b0;
        end
    endtask

    task automatic check_edge();
        int p;
        int di;
        p  = (k - 1) % 8;
        di = ((k - 1) / 8) % 4;
        chk("frame_tick", 32'(frame_tick), 32'((k % 32) == 0));
        if (p < 2) begin
            chk("sel_dead", 32'(digit_sel), 32'(0));
            chk("bl_dead",  32'(digit_bl),  32'(0));
            chk("bcd_dead", 32'(digit_bcd), 32'(0));
        end else begin
            chk("sel", 32'(digit_sel), exp_en ? (32'(1) << di) : 32'(0));
            chk("bl",  32'(digit_bl),  32'(exp_bl[di]));
            chk("bcd", 32'(digit_bcd), 32'(exp_val[4*di +: 4]));
        end
    endtask

    task automatic run_frame();
        for (int e = 0; e < 32; e++) begin
            tick();
            check_edge();
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_sel",  32'(digit_sel),  32'(0));
        chk("rst_bl",   32'(digit_bl),   32'(0));
        chk("rst_bcd",  32'(digit_bcd),  32'(0));
        chk("rst_tick", 32'(frame_tick), 32'(0));
    endtask

    task automatic do_reset();
        e1  = 0;
        e2  = 0;
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst  = 1'b0;
        load = 1'b0;
        k    = 0;
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        bcd_in = '0;
        lzb_en = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        check_reset_outputs();
        rst = 1'b0;
        k   = 0;

        // Frame 1 shows zeros; 0x1234 loaded at edge 3 appears in frame 2
        e1 = 3; v1 = 16'h1234;
        exp_val = 16'h0000; exp_bl = 4'b1111; exp_en = 1'b1;
        run_frame();
        e1 = 40; v1 = 16'h0050;
        lzb_en = 1'b1;
        exp_val = 16'h1234; exp_bl = 4'b1111;
        run_frame();

        // Leading-zero blanking of 0x0050, then of 0x0000
        e1 = 70; v1 = 16'h0000;
        exp_val = 16'h0050; exp_bl = 4'b0011;
        run_frame();
        e1 = 100; v1 = 16'h00A7;
        exp_val = 16'h0000; exp_bl = 4'b0001;
        run_frame();

        // Invalid code A blanks, interior zero still shows without blanking
        lzb_en = 1'b0;
        e1 = 0;
        exp_val = 16'h0007; exp_bl = 4'b1101;
        run_frame();

        // Display disabled: selects stay off, everything else keeps going
        enable = 1'b0;
        exp_en = 1'b0;
        run_frame();
        enable = 1'b1;
        exp_en = 1'b1;

        // Load landing on the frame-boundary edge shows one frame later
        do_reset();
        e1 = 3;  v1 = 16'h1111;
        e2 = 32; v2 = 16'h2222;
        exp_val = 16'h0000; exp_bl = 4'b1111;
        run_frame();
        e1 = 0; e2 = 0;
        exp_val = 16'h1111;
        run_frame();
        exp_val = 16'h2222;
        run_frame();

        // Reset at edge 13 aborts the scan, clears shadow, ignores load during reset
        do_reset();
        e1 = 3;  v1 = 16'h9876;
        e2 = 13; v2 = 16'h5555;
        exp_val = 16'h0000; exp_bl = 4'b1111;
        for (int e = 0; e < 12; e++) begin
            tick();
            check_edge();
        end
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst  = 1'b0;
        load = 1'b0;
        e1   = 0;
        e2   = 0;
        k    = 0;
        run_frame();
        run_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_scan_mux.md
# disp_scan_mux

Time-multiplexed digit scanner for a common-cathode multi-digit 7-segment display. It holds an NDIG-digit packed BCD value and presents one digit at a time as a 4-bit BCD code plus an active-high "show" strobe. Those two signals drive the BCD-to-7-segment decoder's data and blanking inputs. It also drives the one-hot digit-select lines. It sits directly upstream of that decoder and adds double-buffered value loading, anti-ghosting dead time, leading-zero blanking and invalid-code blanking.

## Interface
- NDIG, 4: number of digits, 2..8; digit 0 is least significant.
- PRESCALE, 50000: clock cycles per digit slot; must be greater than DEAD.
- DEAD, 16: cycles at the start of each slot during which no digit is selected; 0 is allowed.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures bcd_in into the shadow register.
- bcd_in  in  4*NDIG  packed BCD value; digit i is bits [4i+3:4i].
- lzb_en  in  1  leading-zero blanking enable.
- enable  in  1  display enable; 0 forces digit_sel to 0.
- digit_bcd  out  4  BCD code of the current digit; drives the decoder data input.
- digit_bl  out  1  1 = show and 0 = blank; drives the decoder blanking input, which blanks on 0.
- digit_sel  out  NDIG  one-hot, active-high digit enable.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

## Operation
- State:
  - prescale counter cnt, 0..PRESCALE-1;
  - digit index idx, 0..NDIG-1;
  - shadow register;
  - active register, 4*NDIG bits each.
- cnt increments every cycle. At cnt == PRESCALE-1:
  - cnt returns to 0;
  - idx advances by 1 and wraps from NDIG-1 to 0.
- Frame boundary is the edge where idx wraps NDIG-1 -> 0. On that edge:
  - active <= shadow;
  - frame_tick pulses for one cycle.
- Load: on an edge with load=1, shadow <= bcd_in. The value reaches the display only at the next frame boundary, so the display never tears mid-frame.
- Load on the frame-boundary edge: shadow takes the new value and active takes the old shadow. The new value appears one frame later.
- Slot phases:
  - BLANK while cnt < DEAD;
  - SHOW while cnt >= DEAD.
- In BLANK: digit_sel=0, digit_bl=0, digit_bcd=0.
- In SHOW:
  - digit_sel = enable ? (1<<idx) : 0;
  - digit_bl and digit_bcd are taken from active digit idx, subject to the blanking rules below.
- A digit is blanked (digit_bl=0, digit_bcd=0) when either of these holds:
  - its code is greater than 9;
  - lzb_en=1, idx != 0, and active digits idx..NDIG-1 are all zero.
- Digit 0 is never blanked by leading-zero blanking.
- Blanked digits keep their digit_sel pulse. Only the decoder output goes dark.
- enable affects only digit_sel. Counters, loading and frame_tick keep running.

## Timing
- All outputs are registered. Edge k is the k-th rising edge with rst=0; edge 1 is the first one after reset is released.
- Outputs after edge k reflect slot position p=(k-1) mod PRESCALE and index ((k-1) div PRESCALE) mod NDIG. Slot p is in BLANK when p < DEAD and in SHOW otherwise.
- The first frame after reset displays active=0.
- frame_tick is high after edge NDIG*PRESCALE*m, for m >= 1.
- Reset sets, on the next edge:
  - digit_sel=0, digit_bl=0, digit_bcd=0, frame_tick=0;
  - cnt=0, idx=0, shadow=0, active=0.
- Reset mid-slot or mid-frame aborts the scan; numbering restarts at edge 1 after release.
- load is ignored while rst=1.
- lzb_en and enable are sampled every cycle and take effect on the next edge. No frame alignment applies to them.

## Test plan
All scenarios use NDIG=4, PRESCALE=8, DEAD=2.

1. Reset, then load=1 with bcd_in=0x1234 at edge 3, lzb_en=0, enable=1:
   - edges 1-32: digit_bcd shows 0 in every SHOW phase;
   - after edge 32: frame_tick=1;
   - after edges 33-34: digit_sel=0000;
   - after edges 35-40: digit_sel=0001, digit_bcd=4, digit_bl=1;
   - subsequent slots show 3, 2, 1 on sel 0010, 0100, 1000.
2. Load 0x0050 with lzb_en=1. In the following frame:
   - digits 3 and 2 show digit_bl=0, digit_bcd=0, while sel still pulses 1000 and 0100;
   - digit 1 shows 5/bl=1; digit 0 shows 0/bl=1.
   Then load 0x0000: only digit 0 shows bl=1, with code 0.
3. Load 0x00A7 with lzb_en=0:
   - digit 1 has bl=0, bcd=0;
   - digit 2 shows 0 with bl=1;
   - digit 0 shows 7.
4. Load 0x1111 then 0x2222, with the 0x2222 load on the frame-boundary edge 32:
   - frame 2 (edges 33-64) shows 1111;
   - frame 3 shows 2222.
5. enable=0 for a whole frame: digit_sel stays 0000, frame_tick still pulses after edge 32, and digit_bcd/digit_bl still sequence normally.
6. Assert rst at edge 13 for one cycle:
   - after that edge, all outputs are 0;
   - after release, the edge numbering and the first-frame blank behaviour of scenario 1 repeat exactly.
